// File: rtl/pc_sequencer.sv
// Instruction sequencer: owns the cpu pc, holds each instruction for SETTLE_CYC
// cycles (plus stall bubbles), then retires it by loading the cpu's next-PC.
module pc_sequencer #(
  parameter int          PC_W       = 16,
  parameter int          SETTLE_CYC = 2,
  parameter int unsigned MAX_INSTR  = 32'h0000_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  input  logic            halt_req,
  input  logic            stall,
  input  logic [PC_W-1:0] cpu_pc_out,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            retire,
  output logic            taken,
  output logic            bubble,
  output logic [15:0]     instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]      SETTLE_RELOAD = 8'(SETTLE_CYC - 1);
  localparam logic [PC_W-1:0] PC_ONE        = PC_W'(1);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [7:0]      settle, settle_nxt;
  logic [15:0]     count_nxt;
  logic            halt_pend, halt_pend_nxt;
  logic            retire_nxt, taken_nxt;
  logic            stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      settle      <= '0;
      instr_count <= '0;
      halt_pend   <= 1'b0;
      retire      <= 1'b0;
      taken       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      settle      <= settle_nxt;
      instr_count <= count_nxt;
      halt_pend   <= halt_pend_nxt;
      retire      <= retire_nxt;
      taken       <= taken_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    settle_nxt    = settle;
    count_nxt     = instr_count;
    halt_pend_nxt = halt_pend;
    retire_nxt    = 1'b0;
    taken_nxt     = 1'b0;
    stop          = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt     = EXEC;
          pc_nxt        = start_pc;
          settle_nxt    = SETTLE_RELOAD;
          count_nxt     = '0;
          halt_pend_nxt = halt_req;
        end
      end
      EXEC: begin
        if (halt_req) halt_pend_nxt = 1'b1;
        if (!stall) begin
          if (settle != 8'd0) begin
            settle_nxt = settle - 8'd1;
          end else begin
            // A halt arriving in the retire cycle itself still ends the run here
            stop = halt_pend || halt_req || (cpu_pc_out == pc) ||
                   ((32'(instr_count) + 32'd1) == MAX_INSTR);
            pc_nxt     = cpu_pc_out;
            count_nxt  = instr_count + 16'd1;
            settle_nxt = SETTLE_RELOAD;
            retire_nxt = 1'b1;
            taken_nxt  = (cpu_pc_out != (pc + PC_ONE));
            if (stop) begin
              state_nxt     = DONE;
              halt_pend_nxt = 1'b0;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state == EXEC);
  assign done   = (state == DONE);
  assign bubble = busy & stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected retires and
// cycle-tagged probes; a single negedge monitor pops and compares them.
module tb_pc_sequencer;

  typedef struct packed {
    logic [15:0] pc;
    logic        busy;
    logic        done;
    logic        retire;
    logic        taken;
    logic        bubble;
    logic [15:0] count;
  } obs_t;

  typedef struct packed {
    int   tag;
    int   sel;
    int   id;
    obs_t exp;
  } probe_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_pc = '0;
  logic        halt_req = 1'b0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [15:0] cpu_pc_out;
  logic [15:0] pc, instr_count;
  logic        busy, done, retire, taken, bubble;

  logic        lim_start = 1'b0;
  logic [15:0] lim_cpu_pc_out;
  logic [15:0] lim_pc, lim_count;
  logic        lim_busy, lim_done, lim_retire, lim_taken, lim_bubble;

  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  int     probe_id = 0;
  logic   end_req = 1'b0;
  obs_t   ret_q[$];
  probe_t probe_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple cpu model: sequential flow, optional branch 14->4, self-loop at 20
  assign cpu_pc_out = (branch_en && pc == 16'd14) ? 16'd4 :
                      (pc == 16'd20) ? 16'd20 : pc + 16'd1;
  assign lim_cpu_pc_out = lim_pc + 16'd1;

  pc_sequencer #(.PC_W(16), .SETTLE_CYC(2), .MAX_INSTR(32'h0000_FFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .halt_req(halt_req), .stall(stall), .cpu_pc_out(cpu_pc_out),
    .pc(pc), .busy(busy), .done(done), .retire(retire), .taken(taken),
    .bubble(bubble), .instr_count(instr_count)
  );

  pc_sequencer #(.PC_W(16), .SETTLE_CYC(2), .MAX_INSTR(32'd3)) dut_lim (
    .clk(clk), .rst(rst), .start(lim_start), .start_pc(16'd100),
    .halt_req(1'b0), .stall(1'b0), .cpu_pc_out(lim_cpu_pc_out),
    .pc(lim_pc), .busy(lim_busy), .done(lim_done), .retire(lim_retire),
    .taken(lim_taken), .bubble(lim_bubble), .instr_count(lim_count)
  );

  function automatic obs_t mk(input logic [15:0] p, input logic b, input logic d,
                              input logic r, input logic t, input logic bb,
                              input logic [15:0] c);
    obs_t o;
    o.pc = p; o.busy = b; o.done = d; o.retire = r;
    o.taken = t; o.bubble = bb; o.count = c;
    return o;
  endfunction

  function automatic obs_t observe(input int sel);
    if (sel == 1)
      return mk(lim_pc, lim_busy, lim_done, lim_retire, lim_taken, lim_bubble, lim_count);
    return mk(pc, busy, done, retire, taken, bubble, instr_count);
  endfunction

  task automatic applyStimulus(input logic s, input logic [15:0] spc, input logic h,
                               input logic st, input logic r);
    @(posedge clk);
    #1;
    start    = s;
    start_pc = spc;
    halt_req = h;
    stall    = st;
    rst      = r;
  endtask

  task automatic checkOutput(input int sel, input logic [15:0] p, input logic b,
                             input logic d, input logic r, input logic t,
                             input logic bb, input logic [15:0] c);
    probe_t pr;
    pr.tag = cyc;
    pr.sel = sel;
    pr.id  = probe_id;
    pr.exp = mk(p, b, d, r, t, bb, c);
    probe_id++;
    probe_q.push_back(pr);
  endtask

  task automatic expectRetire(input logic [15:0] p, input logic t, input logic d,
                              input logic [15:0] c);
    ret_q.push_back(mk(p, !d, d, 1'b1, t, 1'b0, c));
  endtask

  // Monitor: the only process that compares and counts
  always @(negedge clk) begin
    obs_t   act;
    probe_t pr;
    obs_t   ex;
    while (probe_q.size() > 0 && probe_q[0].tag <= cyc) begin
      pr = probe_q.pop_front();
      vectors++;
      act = observe(pr.sel);
      if (pr.tag != cyc || act !== pr.exp) begin
        miscompares++;
        $display("[TB] FAIL probe%0d dut%0d cyc=%0d got pc=%h busy=%b done=%b ret=%b tak=%b bub=%b cnt=%0d expected pc=%h busy=%b done=%b ret=%b tak=%b bub=%b cnt=%0d",
                 pr.id, pr.sel, cyc, act.pc, act.busy, act.done, act.retire, act.taken,
                 act.bubble, act.count, pr.exp.pc, pr.exp.busy, pr.exp.done,
                 pr.exp.retire, pr.exp.taken, pr.exp.bubble, pr.exp.count);
      end
    end
    if (retire === 1'b1) begin
      vectors++;
      act = observe(0);
      if (ret_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL retire_unexpected cyc=%0d got pc=%h cnt=%0d expected no retire",
                 cyc, act.pc, act.count);
      end else begin
        ex = ret_q.pop_front();
        if (act !== ex) begin
          miscompares++;
          $display("[TB] FAIL retire cyc=%0d got pc=%h tak=%b done=%b cnt=%0d expected pc=%h tak=%b done=%b cnt=%0d",
                   cyc, act.pc, act.taken, act.done, act.count, ex.pc, ex.taken, ex.done, ex.count);
        end
      end
    end
    if (end_req || cyc > 2000) begin
      vectors++;
      if (cyc > 2000 || ret_q.size() != 0 || probe_q.size() != 0) begin
        miscompares++;
        $display("[TB] FAIL drain cyc=%0d got %0d retires %0d probes pending expected 0 0",
                 cyc, ret_q.size(), probe_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    // Reset state
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    checkOutput(0, 16'd0, 0, 0, 0, 0, 0, 16'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(0, 16'd0, 0, 0, 0, 0, 0, 16'd0);

    // Run 1: sequential, stall during pc=6, halt in first settle cycle of pc=10
    for (int k = 1; k <= 11; k++) expectRetire(16'(k), 1'b0, k == 11, 16'(k));
    for (int c = 0; c <= 28; c++) begin
      applyStimulus(c == 0, 16'd0, c == 24, c >= 14 && c <= 16, 1'b0);
      case (c)
        1:  checkOutput(0, 16'd0,  1, 0, 0, 0, 0, 16'd0);
        2:  checkOutput(0, 16'd0,  1, 0, 0, 0, 0, 16'd0);
        3:  checkOutput(0, 16'd1,  1, 0, 1, 0, 0, 16'd1);
        4:  checkOutput(0, 16'd1,  1, 0, 0, 0, 0, 16'd1);
        5:  checkOutput(0, 16'd2,  1, 0, 1, 0, 0, 16'd2);
        6:  checkOutput(0, 16'd2,  1, 0, 0, 0, 0, 16'd2);
        13: checkOutput(0, 16'd6,  1, 0, 1, 0, 0, 16'd6);
        14: checkOutput(0, 16'd6,  1, 0, 0, 0, 1, 16'd6);
        15: checkOutput(0, 16'd6,  1, 0, 0, 0, 1, 16'd6);
        16: checkOutput(0, 16'd6,  1, 0, 0, 0, 1, 16'd6);
        17: checkOutput(0, 16'd6,  1, 0, 0, 0, 0, 16'd6);
        18: checkOutput(0, 16'd7,  1, 0, 1, 0, 0, 16'd7);
        24: checkOutput(0, 16'd10, 1, 0, 1, 0, 0, 16'd10);
        25: checkOutput(0, 16'd10, 1, 0, 0, 0, 0, 16'd10);
        26: checkOutput(0, 16'd11, 0, 1, 1, 0, 0, 16'd11);
        27: checkOutput(0, 16'd11, 0, 1, 0, 0, 0, 16'd11);
        28: checkOutput(0, 16'd11, 0, 1, 0, 0, 0, 16'd11);
        default: ;
      endcase
    end

    // Run 2: restart from DONE at 1, branch 14->4, then self-loop at 20
    for (int k = 1; k <= 13; k++) expectRetire(16'(k + 1), 1'b0, 1'b0, 16'(k));
    expectRetire(16'd4, 1'b1, 1'b0, 16'd14);
    for (int k = 15; k <= 30; k++) expectRetire(16'(k - 10), 1'b0, 1'b0, 16'(k));
    expectRetire(16'd20, 1'b1, 1'b1, 16'd31);
    branch_en = 1'b1;
    for (int c = 0; c <= 64; c++) begin
      applyStimulus(c == 0, 16'd1, 1'b0, 1'b0, 1'b0);
      if (c == 29) branch_en = 1'b0;
      case (c)
        1:  checkOutput(0, 16'd1,  1, 0, 0, 0, 0, 16'd0);
        3:  checkOutput(0, 16'd2,  1, 0, 1, 0, 0, 16'd1);
        27: checkOutput(0, 16'd14, 1, 0, 1, 0, 0, 16'd13);
        29: checkOutput(0, 16'd4,  1, 0, 1, 1, 0, 16'd14);
        30: checkOutput(0, 16'd4,  1, 0, 0, 0, 0, 16'd14);
        61: checkOutput(0, 16'd20, 1, 0, 1, 0, 0, 16'd30);
        62: checkOutput(0, 16'd20, 1, 0, 0, 0, 0, 16'd30);
        63: checkOutput(0, 16'd20, 0, 1, 1, 1, 0, 16'd31);
        64: checkOutput(0, 16'd20, 0, 1, 0, 0, 0, 16'd31);
        default: ;
      endcase
    end

    // Run 3: reset mid-run while pc=3
    for (int k = 1; k <= 3; k++) expectRetire(16'(k), 1'b0, 1'b0, 16'(k));
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(c == 0 || c == 7, 16'd0, 1'b0, 1'b0, c == 7);
      case (c)
        7: checkOutput(0, 16'd3, 1, 0, 1, 0, 0, 16'd3);
        8: checkOutput(0, 16'd0, 0, 0, 0, 0, 0, 16'd0);
        9: checkOutput(0, 16'd0, 0, 0, 0, 0, 0, 16'd0);
        default: ;
      endcase
    end

    // Run 4: wrap FFFF->0 is not taken; halt raised in the retire cycle of pc=0
    expectRetire(16'd0, 1'b0, 1'b0, 16'd1);
    expectRetire(16'd1, 1'b0, 1'b1, 16'd2);
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(c == 0, 16'hFFFF, c == 4, 1'b0, 1'b0);
      case (c)
        1: checkOutput(0, 16'hFFFF, 1, 0, 0, 0, 0, 16'd0);
        3: checkOutput(0, 16'd0,    1, 0, 1, 0, 0, 16'd1);
        4: checkOutput(0, 16'd0,    1, 0, 0, 0, 0, 16'd1);
        5: checkOutput(0, 16'd1,    0, 1, 1, 0, 0, 16'd2);
        6: checkOutput(0, 16'd1,    0, 1, 0, 0, 0, 16'd2);
        default: ;
      endcase
    end

    // Run 5: MAX_INSTR=3 instance stops after exactly three retires
    for (int c = 0; c <= 10; c++) begin
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
      lim_start = (c == 0);
      case (c)
        1:  checkOutput(1, 16'd100, 1, 0, 0, 0, 0, 16'd0);
        3:  checkOutput(1, 16'd101, 1, 0, 1, 0, 0, 16'd1);
        5:  checkOutput(1, 16'd102, 1, 0, 1, 0, 0, 16'd2);
        7:  checkOutput(1, 16'd103, 0, 1, 1, 0, 0, 16'd3);
        8:  checkOutput(1, 16'd103, 0, 1, 0, 0, 0, 16'd3);
        10: checkOutput(1, 16'd103, 0, 1, 0, 0, 0, 16'd3);
        default: ;
      endcase
    end

    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    end_req = 1'b1;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction sequencer that owns the `pc` input of the `cpu` core and steps it through a program without testbench intervention. Each instruction is held on `pc` for a fixed number of settle cycles, plus any externally requested bubble cycles. The block then retires it by loading the core's computed next address (`pc_out`), so sequential flow and taken branches (e.g. `beq`) are both handled. It sits between the top level and `cpu`, and replaces hand-driven PC stepping.

## Interface
Parameters:
- `PC_W`, 16, width of the program counter and of `cpu` `pc`/`pc_out`.
- `SETTLE_CYC`, 2, cycles each instruction is held on `pc` before retire; legal range 1..255.
- `MAX_INSTR`, 16'hFFFF, retire count at which the run stops.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run at `start_pc`; honoured in IDLE and DONE only.
- `start_pc`  in  PC_W  first instruction address, sampled with `start`.
- `halt_req`  in  1  stop request, sticky until the next retire.
- `stall`  in  1  insert a bubble this cycle; freezes the settle counter.
- `cpu_pc_out`  in  PC_W  next-PC from `cpu`, valid in the last settle cycle.
- `pc`  out  PC_W  address driven to `cpu`.
- `busy`  out  1  high in EXEC.
- `done`  out  1  high in DONE.
- `retire`  out  1  one-cycle pulse, coincident with the new `pc` value.
- `taken`  out  1  with `retire`: retired next-PC ≠ old `pc`+1 (mod 2^PC_W).
- `bubble`  out  1  high in any EXEC cycle where `stall`=1.
- `instr_count`  out  16  number of instructions retired this run.

## Operation
- States: IDLE, EXEC, DONE. Encode in 2 bits.
- IDLE → EXEC on `start`:
  - `pc`←`start_pc`; `settle`←`SETTLE_CYC`-1.
  - `instr_count`←0.
  - `halt_pend`←`halt_req`.
- EXEC, each cycle:
  - `stall`=1: `bubble`=1; `settle` and `pc` are held.
  - `stall`=0 and `settle`≠0: `settle` decrements.
  - `stall`=0 and `settle`=0 (retire cycle):
    - `pc`←`cpu_pc_out`.
    - `instr_count`++.
    - `retire`,`taken` registered.
    - `settle`←`SETTLE_CYC`-1.
- `halt_req` in EXEC sets `halt_pend`. A `halt_req` in the retire cycle itself counts for that retire.
- Stop conditions, evaluated in the retire cycle; any one true → DONE:
  - `halt_pend`.
  - `cpu_pc_out`==`pc` (self-loop is the program-end convention).
  - `instr_count`+1 == `MAX_INSTR`.
- On stop, the `pc` update and count still occur. `halt_pend` is cleared on entering DONE.
- DONE: `pc` and `instr_count` are held. `start` restarts exactly as from IDLE.
- `start` and `halt_req` in EXEC are ignored, except that `halt_req` latches as above.
- `halt_req` in IDLE/DONE without `start` is ignored.

## Timing
- Reset values: state IDLE; `pc`=0; `busy`=0; `done`=0; `retire`=0; `taken`=0; `bubble`=0; `instr_count`=0; `halt_pend`=0.
- Mid-run reset: `rst` has priority over all inputs, and every output reaches its reset value after that edge.
- Start latency: `start` sampled at edge E → `pc`=`start_pc` and `busy`=1 from E.
- Per-instruction occupancy is `SETTLE_CYC` + (stall cycles).
- With no stalls, a retire edge occurs every `SETTLE_CYC` edges, the first at E+`SETTLE_CYC`.
- `retire` and `taken` are high for exactly the one cycle following a retire edge. They are never high in IDLE or DONE, except in the cycle immediately after the final retire.
- `done` rises on the same edge as the final `pc` update. `busy` falls on that edge.
- `bubble` is combinational: `busy` & `stall`.
- PC arithmetic for `taken` is modulo 2^PC_W: `pc`=16'hFFFF with `cpu_pc_out`=0 → `taken`=0.
- `instr_count` never wraps, because the run stops at `MAX_INSTR`.

## Test plan
- Sequential run:
  - Stimulus: `SETTLE_CYC`=2, `start_pc`=0, `cpu_pc_out`=`pc`+1.
  - Required: `pc` reads 0,0,1,1,2,2,…; `retire` pulses every 2 cycles; `taken`=0.
- Branch:
  - Stimulus: at `pc`=14, drive `cpu_pc_out`=4.
  - Required: the next `pc` is 4, with `taken`=1 for one cycle.
- Stall:
  - Stimulus: assert `stall` for 3 cycles during `pc`=6.
  - Required: `pc`=6 is held for 5 cycles; `bubble` is high for 3 cycles; `instr_count` increments once.
- Halt:
  - Stimulus: pulse `halt_req` in the first settle cycle of `pc`=10.
  - Required: the retire to 11 occurs, then `done`=1, `busy`=0, and `pc` stays at 11 while `instr_count` holds.
  - Stimulus: a self-loop (`cpu_pc_out`=`pc`=20).
  - Required: DONE after one retire.
- Reset and restart:
  - Stimulus: assert `rst` at `pc`=3, mid-run.
  - Required: the next cycle shows `pc`=0 and all flags 0.
  - Stimulus: `start` with `start_pc`=1 from DONE.
  - Required: `instr_count` restarts at 0.
- Limits:
  - Stimulus: `MAX_INSTR`=3.
  - Required: DONE after exactly 3 retires.
  - Stimulus: `start_pc`=16'hFFFF and `cpu_pc_out`=0.
  - Required: `pc` wraps to 0 with `taken`=0.
